// File: rtl/rx_sync_ctrl_if.sv
// Byte-side bundle between the 1:8 deserializer and the receive sync controller.
// master = deserializer/consumer side, slave = rx_sync_ctrl.
interface rx_sync_ctrl_if;
    logic [7:0] byte_in;
    logic       byte_strobe;
    logic       byte_err;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       bitslip;
    logic [7:0] loss_cnt;

    modport master (
        output byte_in,
        output byte_strobe,
        output byte_err,
        input  data_out,
        input  valid_out,
        input  active,
        input  bitslip,
        input  loss_cnt
    );

    modport slave (
        input  byte_in,
        input  byte_strobe,
        input  byte_err,
        output data_out,
        output valid_out,
        output active,
        output bitslip,
        output loss_cnt
    );
endinterface

// File: rtl/rx_sync_ctrl.sv
// Receive byte-alignment controller: hunts for COM, requests bitslips, declares lock,
// forwards data bytes and drops back to hunting on sustained symbol errors.
module rx_sync_ctrl #(
    parameter logic [7:0]  COM_SYM      = 8'hBC,
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned SLIP_TIMEOUT = 16,
    parameter int unsigned ERR_LIMIT    = 3
) (
    input  logic          clk_4f,
    input  logic          reset,
    rx_sync_ctrl_if.slave bus
);

    localparam logic [2:0] LockLast = 3'(LOCK_COUNT);
    localparam logic [7:0] SlipLast = 8'(SLIP_TIMEOUT - 1);
    localparam logic [2:0] ErrLast  = 3'(ERR_LIMIT);

    typedef enum logic [1:0] {
        StHunt,
        StLocking,
        StSynced
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] com_run_q, com_run_d;
    logic [2:0] err_run_q, err_run_d;
    logic [7:0] slip_timer_q, slip_timer_d;
    logic [7:0] data_out_q, data_out_d;
    logic       valid_q, valid_d;
    logic       active_q, active_d;
    logic       bitslip_q, bitslip_d;
    logic [7:0] loss_cnt_q, loss_cnt_d;

    logic       is_com;
    logic [2:0] com_run_inc;
    logic [2:0] err_run_inc;

    // An errored byte never qualifies as COM, even if its value matches.
    assign is_com      = (bus.byte_in == COM_SYM) && !bus.byte_err;
    assign com_run_inc = com_run_q + 3'd1;
    assign err_run_inc = err_run_q + 3'd1;

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state_q      <= StHunt;
            com_run_q    <= 3'd0;
            err_run_q    <= 3'd0;
            slip_timer_q <= 8'd0;
            data_out_q   <= 8'd0;
            valid_q      <= 1'b0;
            active_q     <= 1'b0;
            bitslip_q    <= 1'b0;
            loss_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            com_run_q    <= com_run_d;
            err_run_q    <= err_run_d;
            slip_timer_q <= slip_timer_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            active_q     <= active_d;
            bitslip_q    <= bitslip_d;
            loss_cnt_q   <= loss_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        com_run_d    = com_run_q;
        err_run_d    = err_run_q;
        slip_timer_d = slip_timer_q;
        data_out_d   = data_out_q;
        loss_cnt_d   = loss_cnt_q;
        valid_d      = 1'b0;
        bitslip_d    = 1'b0;

        if (bus.byte_strobe) begin
            unique case (state_q)
                StHunt: begin
                    if (is_com) begin
                        state_d      = StLocking;
                        com_run_d    = 3'd1;
                        slip_timer_d = 8'd0;
                    end else if (slip_timer_q == SlipLast) begin
                        bitslip_d    = 1'b1;
                        slip_timer_d = 8'd0;
                    end else begin
                        slip_timer_d = slip_timer_q + 8'd1;
                    end
                end
                StLocking: begin
                    if (is_com) begin
                        com_run_d = com_run_inc;
                        if (com_run_inc == LockLast) begin
                            state_d = StSynced;
                        end
                    end else begin
                        state_d      = StHunt;
                        com_run_d    = 3'd0;
                        slip_timer_d = 8'd0;
                    end
                end
                StSynced: begin
                    if (bus.byte_err) begin
                        err_run_d = err_run_inc;
                        if (err_run_inc == ErrLast) begin
                            state_d      = StHunt;
                            com_run_d    = 3'd0;
                            err_run_d    = 3'd0;
                            slip_timer_d = 8'd0;
                            if (loss_cnt_q != 8'hFF) begin
                                loss_cnt_d = loss_cnt_q + 8'd1;
                            end
                        end
                    end else if (is_com) begin
                        err_run_d = 3'd0;
                    end else begin
                        data_out_d = bus.byte_in;
                        valid_d    = 1'b1;
                        err_run_d  = 3'd0;
                    end
                end
                default: begin
                    state_d = StHunt;
                end
            endcase
        end

        active_d = (state_d == StSynced);
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_q;
    assign bus.active    = active_q;
    assign bus.bitslip   = bitslip_q;
    assign bus.loss_cnt  = loss_cnt_q;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Scoreboard bench for rx_sync_ctrl: directed byte streams, expected forwarded bytes queued
// at issue time and checked by a separate monitor on valid_out.
module tb_rx_sync_ctrl;

    logic clk_4f = 1'b0;
    logic reset  = 1'b1;

    rx_sync_ctrl_if bus ();

    rx_sync_ctrl #(
        .COM_SYM     (8'hBC),
        .LOCK_COUNT  (4),
        .SLIP_TIMEOUT(16),
        .ERR_LIMIT   (3)
    ) dut (
        .clk_4f(clk_4f),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_4f = ~clk_4f;

    int         vectors     = 0;
    int         miscompares = 0;
    int         bitslip_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the active edge; outputs are stable at that point too.
    task automatic tick(input logic strobe, input logic [7:0] b, input logic e);
        bus.byte_strobe = strobe;
        bus.byte_in     = b;
        bus.byte_err    = e;
        @(posedge clk_4f);
        #1;
        bus.byte_strobe = 1'b0;
    endtask

    task automatic send_com(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 8'hBC, 1'b0);
    endtask

    task automatic send_data(input logic [7:0] b);
        exp_q.push_back(b);
        tick(1'b1, b, 1'b0);
        chk("data_valid", {7'd0, bus.valid_out}, 8'd1);
        chk("data_byte", bus.data_out, b);
    endtask

    // Monitor: every forwarded byte must match the head of the scoreboard queue.
    always @(negedge clk_4f) begin
        if (!reset) begin
            if (bus.bitslip) begin
                bitslip_cnt++;
                chk("bitslip_in_hunt", {7'd0, bus.active}, 8'd0);
            end
            if (bus.valid_out) begin
                chk("valid_while_active", {7'd0, bus.active}, 8'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", bus.data_out, 8'h00);
                    miscompares += (bus.data_out == 8'h00) ? 1 : 0;
                end else begin
                    chk("scoreboard_byte", bus.data_out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bus.byte_in     = 8'h00;
        bus.byte_strobe = 1'b0;
        bus.byte_err    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_4f);
        #1;
        chk("rst_active", {7'd0, bus.active}, 8'd0);
        chk("rst_valid", {7'd0, bus.valid_out}, 8'd0);
        chk("rst_bitslip", {7'd0, bus.bitslip}, 8'd0);
        chk("rst_data", bus.data_out, 8'h00);
        chk("rst_loss", bus.loss_cnt, 8'h00);
        reset = 1'b0;

        // Lock on 4 COMs, then forward three data bytes
        send_com(3);
        chk("lock_after3", {7'd0, bus.active}, 8'd0);
        send_com(1);
        chk("lock_after4", {7'd0, bus.active}, 8'd1);
        send_data(8'h11);
        send_data(8'h22);
        send_data(8'h33);
        send_com(1);
        chk("com_stripped", {7'd0, bus.valid_out}, 8'd0);
        chk("com_data_hold", bus.data_out, 8'h33);

        // Bitslip timing: 40 non-COM bytes
        reset = 1'b1;
        #1;
        reset = 1'b0;
        bitslip_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 8'h55, 1'b0);
            if (i == 14) chk("slip_before16", {7'd0, bus.bitslip}, 8'd0);
            if (i == 15) chk("slip_at16", {7'd0, bus.bitslip}, 8'd1);
            if (i == 16) chk("slip_width", {7'd0, bus.bitslip}, 8'd0);
            if (i == 31) chk("slip_at32", {7'd0, bus.bitslip}, 8'd1);
        end
        @(negedge clk_4f);
        chk("slip_count", 8'(bitslip_cnt), 8'd2);
        chk("slip_active", {7'd0, bus.active}, 8'd0);

        // Broken COM run restarts the lock count
        reset = 1'b1;
        #1;
        reset = 1'b0;
        send_com(3);
        tick(1'b1, 8'h00, 1'b0);
        send_com(3);
        chk("relock_after3", {7'd0, bus.active}, 8'd0);
        send_com(1);
        chk("relock_after4", {7'd0, bus.active}, 8'd1);
        chk("relock_loss", bus.loss_cnt, 8'd0);

        // Three consecutive errors lose sync
        tick(1'b1, 8'h42, 1'b1);
        tick(1'b1, 8'h42, 1'b1);
        chk("err2_active", {7'd0, bus.active}, 8'd1);
        tick(1'b1, 8'h42, 1'b1);
        chk("err3_active", {7'd0, bus.active}, 8'd0);
        chk("err3_loss", bus.loss_cnt, 8'd1);

        // err,err,good,err keeps lock; errored COMs count as errors
        send_com(4);
        tick(1'b1, 8'h42, 1'b1);
        tick(1'b1, 8'h42, 1'b1);
        send_data(8'h77);
        tick(1'b1, 8'h42, 1'b1);
        chk("errgap_active", {7'd0, bus.active}, 8'd1);
        chk("errgap_loss", bus.loss_cnt, 8'd1);
        tick(1'b1, 8'hBC, 1'b1);
        tick(1'b1, 8'hBC, 1'b1);
        chk("errcom_active", {7'd0, bus.active}, 8'd0);
        chk("errcom_loss", bus.loss_cnt, 8'd2);

        // Strobe gaps hold state
        send_com(4);
        send_data(8'hA1);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 8'h99, 1'b0);
            chk("gap_valid", {7'd0, bus.valid_out}, 8'd0);
            chk("gap_active", {7'd0, bus.active}, 8'd1);
        end
        send_data(8'hA2);

        // Asynchronous reset mid-packet
        tick(1'b1, 8'hA3, 1'b0);
        chk("ar_pre_valid", {7'd0, bus.valid_out}, 8'd1);
        chk("ar_pre_data", bus.data_out, 8'hA3);
        reset = 1'b1;
        #1;
        chk("ar_valid", {7'd0, bus.valid_out}, 8'd0);
        chk("ar_active", {7'd0, bus.active}, 8'd0);
        chk("ar_data", bus.data_out, 8'h00);
        chk("ar_loss", bus.loss_cnt, 8'h00);
        chk("ar_bitslip", {7'd0, bus.bitslip}, 8'd0);
        @(posedge clk_4f);
        #1;
        reset = 1'b0;
        send_com(3);
        chk("ar_relock3", {7'd0, bus.active}, 8'd0);
        send_com(1);
        chk("ar_relock4", {7'd0, bus.active}, 8'd1);
        send_data(8'hC5);

        repeat (3) tick(1'b0, 8'h00, 1'b0);
        chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
